// File: rtl/chimera_cfg_sequencer.sv
// chimera_cfg_sequencer: staged power-up sequencer for Chimera cluster configurations.
// A valid/ready request selects a per-configuration cluster mask. Each enabled cluster,
// lowest index first, gets its clock ungated and then its reset released StaggerCycles
// later. The next cluster is ungated one cycle after that release. A one-cycle done_o
// pulse ends the sequence 1 + n*(StaggerCycles+1) cycles after accept.
// Backpressure: req_ready_o is high only while idle. Every output is registered.
// Optional feature: define CHIMERA_CFG_SEQ_ABORT_EN to add abort_i. While a sequence is
// running, abort_i puts every cluster back into reset and gating, sets err_o and
// suppresses done_o.
module chimera_cfg_sequencer #(
  parameter int NumConfigs    = 4,
  parameter int NumClusters   = 5,
  parameter int StaggerCycles = 4,
  parameter int IdxWidth      = (NumConfigs > 1) ? $clog2(NumConfigs) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [IdxWidth-1:0]               req_idx_i,
  input  logic [NumConfigs*NumClusters-1:0] cfg_masks_i,
  output logic [NumClusters-1:0]            cluster_clk_en_o,
  output logic [NumClusters-1:0]            cluster_rst_o,
  output logic [IdxWidth-1:0]               active_idx_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o
`ifdef CHIMERA_CFG_SEQ_ABORT_EN
  ,
  input  logic                              abort_i
`endif
);

  // ptr must be able to hold NumClusters itself: that value means "past the last cluster".
  localparam int PtrW = $clog2(NumClusters + 1);
  localparam int CntW = (StaggerCycles > 1) ? $clog2(StaggerCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(StaggerCycles - 1);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [NumClusters-1:0] mask_q, mask_d;
  logic [PtrW-1:0]        ptr_q, ptr_d;
  logic [PtrW-1:0]        cur_q, cur_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NumClusters-1:0] clk_en_q, clk_en_d;
  logic [NumClusters-1:0] crst_q, crst_d;
  logic [IdxWidth-1:0]    idx_q, idx_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic                   idx_ok;
  logic [NumClusters-1:0] sel_mask;
  logic                   found;
  logic [PtrW-1:0]        found_k;
  logic                   cnt_last;
  logic                   abort_act;

  assign accept   = req_valid_i && ready_q;
  assign cnt_last = (cnt_q == CntLast);

`ifdef CHIMERA_CFG_SEQ_ABORT_EN
  assign abort_act = abort_i && (state_q != IDLE);
`else
  assign abort_act = 1'b0;
`endif

  // Look up the requested configuration's mask. An index that matches no configuration is invalid.
  always_comb begin
    idx_ok   = 1'b0;
    sel_mask = '0;
    for (int c = 0; c < NumConfigs; c++) begin
      if (req_idx_i == IdxWidth'(c)) begin
        idx_ok   = 1'b1;
        sel_mask = cfg_masks_i[c*NumClusters +: NumClusters];
      end
    end
  end

  // Find the lowest set mask bit at or above ptr. The downward loop lets the lowest match win.
  always_comb begin
    found   = 1'b0;
    found_k = '0;
    for (int i = NumClusters - 1; i >= 0; i--) begin
      if (mask_q[i] && (PtrW'(i) >= ptr_q)) begin
        found   = 1'b1;
        found_k = PtrW'(i);
      end
    end
  end

  // Register all state. A synchronous reset overrides both abort and accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      ptr_q    <= '0;
      cur_q    <= '0;
      cnt_q    <= '0;
      clk_en_q <= '0;
      crst_q   <= '1;
      idx_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      ptr_q    <= ptr_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      crst_q   <= crst_d;
      idx_q    <= idx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: IDLE -> SCAN on a valid accept, SCAN -> HOLD per cluster, HOLD -> SCAN after the stagger.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && idx_ok) state_d = SCAN;
      SCAN:    state_d = found ? HOLD : IDLE;
      HOLD:    if (cnt_last) state_d = SCAN;
      default: state_d = IDLE;
    endcase
    if (abort_act) state_d = IDLE;
  end

  // Next values for the datapath and the registered outputs, based on the current state.
  always_comb begin
    mask_d   = mask_q;
    ptr_d    = ptr_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    clk_en_d = clk_en_q;
    crst_d   = crst_q;
    idx_d    = idx_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (idx_ok) begin
            mask_d   = sel_mask;
            idx_d    = req_idx_i;
            crst_d   = '1;
            clk_en_d = '0;
            err_d    = 1'b0;
            ptr_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (found) begin
          for (int i = 0; i < NumClusters; i++) begin
            if (PtrW'(i) == found_k) clk_en_d[i] = 1'b1;
          end
          cur_d = found_k;
          cnt_d = '0;
        end else begin
          done_d = 1'b1;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_last) begin
          for (int i = 0; i < NumClusters; i++) begin
            if (PtrW'(i) == cur_q) crst_d[i] = 1'b0;
          end
          ptr_d = cur_q + PtrW'(1);
        end
      end
      default: ;
    endcase
    if (abort_act) begin
      crst_d   = '1;
      clk_en_d = '0;
      err_d    = 1'b1;
      done_d   = 1'b0;
    end
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  assign req_ready_o      = ready_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign cluster_clk_en_o = clk_en_q;
  assign cluster_rst_o    = crst_q;
  assign active_idx_o     = idx_q;

endmodule

// File: tb/tb_chimera_cfg_sequencer.sv
// Scoreboard bench for chimera_cfg_sequencer (4 configs, 5 clusters, stagger 4).
// Each accepted request pushes its full expected per-cycle output trace, built from the
// bring-up timing. A negedge monitor pops one entry per cycle and compares it with the DUT.
module tb_chimera_cfg_sequencer;

  localparam int NCFG = 4;
  localparam int NCL  = 5;
  localparam int STG  = 4;
  localparam int IW   = 3;  // wide enough to present an out-of-range index such as 5

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [IW-1:0]   req_idx;
  logic [NCFG*NCL-1:0] cfg_masks;
  logic [NCL-1:0]  clk_en;
  logic [NCL-1:0]  crst;
  logic [IW-1:0]   active_idx;
  logic            busy;
  logic            done;
  logic            err;
`ifdef CHIMERA_CFG_SEQ_ABORT_EN
  logic            abort;
`endif

  typedef struct {
    int             t;
    logic [NCL-1:0] en;
    logic [NCL-1:0] rs;
    logic           dn;
    logic           bz;
    logic           rdy;
    logic           er;
    logic [IW-1:0]  idx;
  } exp_t;

  exp_t           exp_q[$];
  logic [NCL-1:0] m [NCFG];
  int             n_chk = 0;
  int             n_err = 0;

  always #5 clk = ~clk;

  chimera_cfg_sequencer #(
    .NumConfigs(NCFG), .NumClusters(NCL), .StaggerCycles(STG), .IdxWidth(IW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_idx_i(req_idx),
    .cfg_masks_i(cfg_masks),
    .cluster_clk_en_o(clk_en),
    .cluster_rst_o(crst),
    .active_idx_o(active_idx),
    .busy_o(busy),
    .done_o(done),
    .err_o(err)
`ifdef CHIMERA_CFG_SEQ_ABORT_EN
    ,
    .abort_i(abort)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Build the expected trace for one request, covering edges E0..min(L, cut) after the accept.
  task automatic push_seq(input int idx, input int cut);
    int   ks[$];
    int   len;
    exp_t e;
    for (int i = 0; i < NCL; i++) if (m[idx][i]) ks.push_back(i);
    len = 1 + ks.size() * (STG + 1);
    for (int t = 0; t <= len && t <= cut; t++) begin
      e.t   = t;
      e.en  = '0;
      e.rs  = '1;
      for (int j = 0; j < ks.size(); j++) begin
        if (t >= 1 + j * (STG + 1))       e.en[ks[j]] = 1'b1;
        if (t >= 1 + j * (STG + 1) + STG) e.rs[ks[j]] = 1'b0;
      end
      e.dn  = (t == len);
      e.bz  = (t != len);
      e.rdy = (t == len);
      e.er  = 1'b0;
      e.idx = IW'(idx);
      exp_q.push_back(e);
    end
  endtask

  // Compare one expected entry per cycle. With nothing queued, done_o must stay low.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk($sformatf("en_t%0d", e.t),    32'(clk_en),     32'(e.en));
      chk($sformatf("rst_t%0d", e.t),   32'(crst),       32'(e.rs));
      chk($sformatf("done_t%0d", e.t),  32'(done),       32'(e.dn));
      chk($sformatf("busy_t%0d", e.t),  32'(busy),       32'(e.bz));
      chk($sformatf("ready_t%0d", e.t), 32'(req_ready),  32'(e.rdy));
      chk($sformatf("err_t%0d", e.t),   32'(err),        32'(e.er));
      chk($sformatf("idx_t%0d", e.t),   32'(active_idx), 32'(e.idx));
    end else if (!rst) begin
      chk("idle_no_done", 32'(done), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait until the scoreboard is empty. A timeout counts as a failure.
  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // Issue one request that the bench expects to be accepted at the next edge.
  task automatic send(input int idx, input int cut);
    step();
    req_valid = 1'b1;
    req_idx   = IW'(idx);
    step();
    req_valid = 1'b0;
    push_seq(idx, cut);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rst"},   32'(crst),       32'h1f);
    chk({tag, "_en"},    32'(clk_en),     32'h0);
    chk({tag, "_ready"}, 32'(req_ready),  32'd1);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_err"},   32'(err),        32'd0);
    chk({tag, "_idx"},   32'(active_idx), 32'd0);
  endtask

  initial begin
    m[0] = 5'b11111;
    m[1] = 5'b10010;
    m[2] = 5'b00101;
    m[3] = 5'b00000;
    cfg_masks = {m[3], m[2], m[1], m[0]};
    rst = 1'b1;
    req_valid = 1'b0;
    req_idx = '0;
`ifdef CHIMERA_CFG_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");

    // cfg 2 = 00101: ungate 0 at E1, release at E5, ungate 2 at E6, release at E10, done at E11.
    // A mask change after the accept must not affect the running sequence.
    send(2, 1000);
    cfg_masks = {m[3], 5'b11111, m[1], m[0]};
    drain();
    cfg_masks = {m[3], m[2], m[1], m[0]};

    // Out-of-range index: only err_o moves, and the block stays ready.
    step();
    req_valid = 1'b1;
    req_idx   = 3'd5;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("bad_err",   32'(err),        32'd1);
    chk("bad_ready", 32'(req_ready),  32'd1);
    chk("bad_busy",  32'(busy),       32'd0);
    chk("bad_en",    32'(clk_en),     32'h05);
    chk("bad_rst",   32'(crst),       32'h1a);
    chk("bad_idx",   32'(active_idx), 32'd2);

    // Empty mask (cfg 3): err clears, done at E1, everything stays gated and in reset.
    send(3, 1000);
    drain();

    // cfg 1 with cfg 0 held on valid: cfg 0 is accepted in the done cycle and completes after 26 cycles.
    step();
    req_valid = 1'b1;
    req_idx   = 3'd1;
    step();
    push_seq(1, 1000);
    push_seq(0, 1000);
    req_idx = 3'd0;
    repeat (1 + 2 * (STG + 1) + 1) @(posedge clk);
    #1 req_valid = 1'b0;
    drain();

    // Synchronous reset during the first cluster's HOLD.
    send(2, 3);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");

`ifdef CHIMERA_CFG_SEQ_ABORT_EN
    // Abort during the second cluster's HOLD (E6..E10), sampled at E8.
    send(2, 7);
    repeat (7) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_rst",   32'(crst),      32'h1f);
    chk("abort_en",    32'(clk_en),    32'h0);
    chk("abort_err",   32'(err),       32'd1);
    chk("abort_done",  32'(done),      32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_busy",  32'(busy),      32'd0);
    repeat (3) @(negedge clk);
    chk("abort_err_sticky", 32'(err),  32'd1);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
